// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace transmitter.
// A trace entry is {cycle, pc, instr}; a frame is SYNC followed by each field little-endian.
package trace_pkg;

    localparam int unsigned FRAME_BYTES  = 13;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

    typedef enum logic {
        StIdle,
        StSend
    } tx_state_e;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_entry_t;

    localparam int unsigned ENTRY_W = $bits(trace_entry_t);
    localparam int unsigned FRAME_W = FRAME_BYTES * 8;

    // Byte 0 of the frame sits in bits [7:0] so the shifter can emit LSB first.
    function automatic logic [FRAME_W-1:0] frame_pack(input trace_entry_t e,
                                                      input logic [7:0]   sync);
        return {e.instr, e.pc, e.cycle, sync};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries with full/empty flags.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/retire_trace_tx.sv
// Captures retired instructions with a cycle stamp and streams each one as a
// 13-byte frame over a valid/ready byte interface, counting events dropped on overflow.
module retire_trace_tx
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ret_valid,
    input  logic [31:0] ret_pc,
    input  logic [31:0] ret_instr,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [31:0]      cyc_q;
    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_d;
    logic [3:0]       idx_q;
    logic [3:0]       idx_d;
    logic             tx_valid_q;
    logic             tx_valid_d;
    logic [7:0]       tx_data_q;
    logic [7:0]       tx_data_d;
    logic             tx_last_q;
    logic             tx_last_d;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    trace_entry_t     push_entry;
    trace_entry_t     pop_entry;
    logic [ENTRY_W-1:0] pop_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             last_accept;
    logic             pop;
    logic             drop;

    assign push_entry  = '{cycle: cyc_q, pc: ret_pc, instr: ret_instr};
    assign pop_entry   = trace_entry_t'(pop_data);
    assign accept      = tx_valid_q && tx_ready;
    assign last_accept = (state_q == StSend) && accept && (idx_q == LAST_IDX);
    assign pop         = !fifo_empty && ((state_q == StIdle) || last_accept);
    assign drop        = ret_valid && fifo_full && !pop;

    trace_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rstn),
        .push     (ret_valid),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (pop_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (last_accept && fifo_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and shifter next-state; outputs are registered so they only move on accept or load.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (pop) begin
            sr_d  = frame_pack(pop_entry, SYNC);
            idx_d = '0;
        end else if (last_accept) begin
            sr_d  = '0;
            idx_d = '0;
        end else if (accept) begin
            sr_d  = sr_q >> 8;
            idx_d = idx_q + 1'b1;
        end
        tx_valid_d = (state_d == StSend);
        tx_data_d  = tx_valid_d ? sr_d[7:0] : 8'h00;
        tx_last_d  = tx_valid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cyc_q      <= '0;
            sr_q       <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cyc_q      <= cyc_q + 32'd1;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx: table of single-frame vectors plus
// hand-written sequences for back-to-back, overflow, mid-frame reset and stamp wrap.
module tb_retire_trace_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] ret_instr = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_pass = 0;
    int n_total = 0;
    int tb_cyc = 0;

    logic [7:0] got_b[$];
    bit         got_l[$];
    int         got_c[$];

    always #5 clk = ~clk;

    // Cycle index since the last reset edge, used to timestamp accepted bytes.
    always @(posedge clk) begin
        if (rstn) tb_cyc <= 0;
        else      tb_cyc <= tb_cyc + 1;
    end

    retire_trace_tx #(
        .DEPTH(4),
        .SYNC (8'hA5)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ret_valid(ret_valid),
        .ret_pc   (ret_pc),
        .ret_instr(ret_instr),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  instr;
        bit           toggle;
        logic [103:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [103:0] mk(input logic [31:0] c, input logic [31:0] pc,
                                        input logic [31:0] instr);
        return {instr, pc, c, 8'hA5};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        ret_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
        ret_valid = 1'b1;
        ret_pc = pc;
        ret_instr = instr;
        @(negedge clk);
        ret_valid = 1'b0;
        ret_pc = 32'hBAD0_BAD0;
        ret_instr = 32'hFFFF_FFFF;
    endtask

    task automatic collect(input int nbytes, input bit toggle);
        bit         rdy = 1'b0;
        bit         stalled = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        int         waited = 0;
        got_b.delete();
        got_l.delete();
        got_c.delete();
        while (got_b.size() < nbytes && waited < 400) begin
            if (stalled) begin
                chk("stall_data", 32'(tx_data), 32'(pd));
                chk("stall_last", 32'(tx_last), 32'(pl));
                chk("stall_valid", 32'(tx_valid), 32'd1);
            end
            rdy = toggle ? !rdy : 1'b1;
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                got_b.push_back(tx_data);
                got_l.push_back(tx_last);
                got_c.push_back(tb_cyc);
            end
            stalled = tx_valid && !rdy;
            pd = tx_data;
            pl = tx_last;
            @(negedge clk);
            waited++;
        end
        tx_ready = 1'b0;
        chk("collect_count", 32'(got_b.size()), 32'(nbytes));
    endtask

    task automatic check_frame(input string name, input int base, input logic [103:0] exp);
        logic [12:0] lv = '0;
        for (int b = 0; b < 13; b++) begin
            if (base + b < got_b.size()) begin
                chk($sformatf("%s_b%0d", name, b), 32'(got_b[base+b]), 32'(exp[8*b +: 8]));
                lv[b] = got_l[base+b];
            end else begin
                chk($sformatf("%s_b%0d_missing", name, b), 32'd0, 32'd1);
            end
        end
        chk($sformatf("%s_last", name), 32'(lv), 32'h1000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   gaps;
        int   vcount;
        logic [103:0] e;

        vecs[0] = '{pc: 32'h0000_0004, instr: 32'h0050_0093, toggle: 1'b0,
                    exp: 104'h00_50_00_93_00_00_00_04_00_00_00_03_A5};
        vecs[1] = '{pc: 32'h0000_0004, instr: 32'h0050_0093, toggle: 1'b1,
                    exp: 104'h00_50_00_93_00_00_00_04_00_00_00_03_A5};
        vecs[2] = '{pc: 32'hDEAD_BEEF, instr: 32'h1234_5678, toggle: 1'b0,
                    exp: 104'h12_34_56_78_DE_AD_BE_EF_00_00_00_03_A5};

        // Reset state
        do_reset();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Single retire at cycle 3, header visible in cycle 5
        for (int i = 0; i < 3; i++) begin
            do_reset();
            repeat (3) @(negedge clk);
            retire(vecs[i].pc, vecs[i].instr);
            chk($sformatf("v%0d_lat_c4", i), 32'(tx_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_hdr_valid_c5", i), 32'(tx_valid), 32'd1);
            chk($sformatf("v%0d_hdr_data_c5", i), 32'(tx_data), 32'hA5);
            collect(13, vecs[i].toggle);
            check_frame($sformatf("v%0d", i), 0, vecs[i].exp);
            chk($sformatf("v%0d_idle_after", i), 32'(tx_valid), 32'd0);
        end

        // Three consecutive retires stream back to back
        do_reset();
        repeat (3) @(negedge clk);
        ret_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ret_pc = 32'h100 + 32'(4 * k);
            ret_instr = 32'hA000_0000 + 32'(k);
            @(negedge clk);
        end
        ret_valid = 1'b0;
        collect(39, 1'b0);
        for (int k = 0; k < 3; k++) begin
            e = mk(32'(3 + k), 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            check_frame($sformatf("b2b_f%0d", k), 13 * k, e);
        end
        gaps = 0;
        for (int j = 1; j < got_c.size(); j++) begin
            if (got_c[j] != got_c[j-1] + 1) gaps++;
        end
        chk("b2b_gap", 32'(gaps), 32'd0);

        // Overflow: six retires while stalled, DEPTH=4
        do_reset();
        repeat (3) @(negedge clk);
        ret_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ret_pc = 32'h200 + 32'(4 * k);
            ret_instr = 32'h1000 + 32'(k);
            @(negedge clk);
        end
        ret_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("ovf_hdr_held", 32'(tx_data), 32'hA5);
        collect(65, 1'b0);
        for (int k = 0; k < 5; k++) begin
            e = mk(32'(3 + k), 32'h200 + 32'(4 * k), 32'h1000 + 32'(k));
            check_frame($sformatf("ovf_f%0d", k), 13 * k, e);
        end
        repeat (5) @(negedge clk);
        chk("ovf_no_sixth", 32'(tx_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a frame with two entries queued
        do_reset();
        repeat (3) @(negedge clk);
        ret_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ret_pc = 32'h0000_1234 + 32'(k);
            ret_instr = 32'h5555_0000 + 32'(k);
            @(negedge clk);
        end
        ret_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_byte7", 32'(tx_data), 32'h12);
        rstn = 1'b1;
        ret_valid = 1'b1;
        ret_pc = 32'h0000_0999;
        @(negedge clk);
        rstn = 1'b0;
        ret_valid = 1'b0;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_last", 32'(tx_last), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        vcount = 0;
        repeat (20) begin
            if (tx_valid) vcount++;
            @(negedge clk);
        end
        chk("mid_rst_silent", 32'(vcount), 32'd0);
        retire(32'h0000_0040, 32'h0000_0077);
        collect(13, 1'b0);
        check_frame("mid_new", 0, mk(32'd20, 32'h0000_0040, 32'h0000_0077));

        // Cycle stamp wrap
        do_reset();
        repeat (2) @(negedge clk);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        ret_valid = 1'b1;
        ret_pc = 32'h0000_0300;
        ret_instr = 32'h0000_0013;
        @(negedge clk);
        ret_pc = 32'h0000_0304;
        ret_instr = 32'h0000_0033;
        @(negedge clk);
        ret_valid = 1'b0;
        collect(26, 1'b0);
        check_frame("wrap_f0", 0, mk(32'hFFFF_FFFF, 32'h0000_0300, 32'h0000_0013));
        check_frame("wrap_f1", 13, mk(32'h0000_0000, 32'h0000_0304, 32'h0000_0033));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/retire_trace_tx.md
RETIRE_TRACE_TX -- requirements
Module: retire_trace_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, trace FIFO entry count (power of two, >=2).
REQ-002 SHALL have parameter SYNC, default 8'hA5, frame header byte.
REQ-003 SHALL have clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have rstn  input  1  reset, synchronous and active-high (asserted = 1).
REQ-005 SHALL have ret_valid  input  1  one instruction retires this cycle.
REQ-006 SHALL have ret_pc  input  32  PC of the retiring instruction.
REQ-007 SHALL have ret_instr  input  32  encoding of the retiring instruction.
REQ-008 SHALL have tx_valid  output  1  tx_data holds a valid byte.
REQ-009 SHALL have tx_data  output  8  trace stream byte.
REQ-010 SHALL have tx_last  output  1  current byte is the last byte of a frame.
REQ-011 SHALL have tx_ready  input  1  consumer accepts the byte when tx_valid && tx_ready.
REQ-012 SHALL have overflow  output  1  sticky flag: at least one retire event dropped.
REQ-013 SHALL have drop_cnt  output  16  count of dropped retire events.

Function
REQ-014 SHALL keep a 32-bit free-running cycle counter: 0 in the first cycle after reset, +1 per cycle, wrapping 32'hFFFFFFFF -> 0.
REQ-015 SHALL, when ret_valid=1 and FIFO not full, push {cycle, ret_pc, ret_instr} sampled in that same cycle.
REQ-016 SHALL emit one 13-byte frame per entry: SYNC, cycle[7:0..31:24], pc[7:0..31:24], instr[7:0..31:24] (little-endian per field).
REQ-017 SHALL assert tx_last only with byte 13 of a frame.
REQ-018 SHALL use FSM states IDLE, SEND: IDLE with FIFO non-empty -> pop entry into 104-bit shift register, byte index 0, go SEND; SEND advances byte index on each accept; accept of byte 13 -> pop and reload if FIFO non-empty (stay SEND, index 0), else IDLE.
REQ-019 SHALL register tx_valid/tx_data/tx_last; tx_valid=1 exactly in SEND.
REQ-020 SHALL hold tx_data and tx_last stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before acceptance.
REQ-021 SHALL present the header two cycles after ret_valid when FIFO empty and FSM IDLE (push at edge N, load at edge N+1, header visible cycle N+2).
REQ-022 SHALL stream back-to-back frames with no idle cycle between byte 13 acceptance and the next header while entries remain.
REQ-023 SHALL, when ret_valid=1 and FIFO full with no pop in the same cycle, drop the event, set overflow, increment drop_cnt saturating at 16'hFFFF.
REQ-024 SHALL accept the push when FIFO full and a pop occurs in the same cycle (no drop).
REQ-025 SHALL ignore ret_pc/ret_instr when ret_valid=0.

Reset
REQ-026 SHALL, while rstn=1 at a clock edge, clear FIFO pointers/count, cycle counter, shift register, byte index, FSM to IDLE, tx_valid=0, tx_data=0, tx_last=0, overflow=0, drop_cnt=0.
REQ-027 SHALL abandon any partially sent frame on reset; no byte of it is resent after reset release.
REQ-028 SHALL ignore ret_valid in cycles where rstn=1.

Structure
REQ-029 SHALL place FRAME_BYTES=13, default SYNC, and the FSM state enum in shared package trace_pkg.
REQ-030 SHALL implement the buffer as sub-module trace_fifo (synchronous, DEPTH x 96 bits, full/empty, simultaneous push/pop).

Verification
REQ-031 Single retire pc=32'h00000004, instr=32'h00500093 at cycle 3, tx_ready=1 -> header in cycle 5, bytes A5 03 00 00 00 04 00 00 00 93 00 50 00, tx_last on byte 13 only.
REQ-032 Same stimulus, tx_ready toggling 1/0 each cycle -> identical byte sequence, tx_data stable during every stalled cycle.
REQ-033 Retires in 3 consecutive cycles, tx_ready=1 -> three 13-byte frames, no gap, cycle stamps consecutive.
REQ-034 tx_ready=0, 6 consecutive retires, DEPTH=4 -> 4 queued plus 1 loaded, 1 dropped, overflow=1, drop_cnt=1; release tx_ready -> 5 frames in order.
REQ-035 Assert rstn at byte 7 of a frame with 2 entries queued -> next cycle tx_valid=0, overflow=0, drop_cnt=0; no frame output until a new retire.
REQ-036 Force cycle counter to 32'hFFFFFFFF, retire there and next cycle -> stamps FF FF FF FF then 00 00 00 00.
